// File: rtl/if_id_fetch_queue_if.sv
// IF->ID fetch-queue handshake bundle: IF push side, ID show-ahead pop side, flush and occupancy.
interface if_id_fetch_queue_if #(
    parameter int PTR_W = 1
);
    logic             flush;
    logic             if_valid;
    logic             if_ready;
    logic [31:0]      if_pc;
    logic [31:0]      if_instr;
    logic [31:0]      if_b_addr;
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_pc;
    logic [31:0]      id_pc_plus4;
    logic [31:0]      id_instr;
    logic [31:0]      id_b_addr;
    logic [PTR_W:0]   count;

    modport slave (
        input  flush, if_valid, if_pc, if_instr, if_b_addr, id_ready,
        output if_ready, id_valid, id_pc, id_pc_plus4, id_instr, id_b_addr, count
    );

    modport master (
        output flush, if_valid, if_pc, if_instr, if_b_addr, id_ready,
        input  if_ready, id_valid, id_pc, id_pc_plus4, id_instr, id_b_addr, count
    );
endinterface

// File: rtl/if_id_fetch_queue.sv
// IF->ID decoupling queue, show-ahead head with single-cycle flush; optional counters via FETCH_QUEUE_STATS_EN.
// Latency: an entry pushed at edge N is visible on id_* after edge N (one cycle IF->ID).
// Backpressure: if_ready drops only when full (no pass-through); id_valid is low when empty.
module if_id_fetch_queue #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    if_id_fetch_queue_if.slave  q
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]         stat_full_cycles,
    output logic [31:0]         stat_flush_cnt
`endif
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] b_addr;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push, pop;
    entry_t           head;

    // Handshake readiness depends only on registered occupancy.
    assign q.if_ready = (cnt_q != FULL_CNT);
    assign q.id_valid = (cnt_q != '0);
    assign push       = q.if_valid && q.if_ready;
    assign pop        = q.id_valid && q.id_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_d = cnt_q + 1'b1;
            else if (pop && !push) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (!rst && !q.flush && push) begin
            mem_q[wr_ptr_q] <= '{pc: q.if_pc, instr: q.if_instr, b_addr: q.if_b_addr};
        end
    end

    assign head          = q.id_valid ? mem_q[rd_ptr_q] : '0;
    assign q.id_pc       = head.pc;
    assign q.id_instr    = head.instr;
    assign q.id_b_addr   = head.b_addr;
    assign q.id_pc_plus4 = head.pc + 32'd4;
    assign q.count       = cnt_q;

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] full_cycles_q, full_cycles_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        full_cycles_d = full_cycles_q;
        flush_cnt_d   = flush_cnt_q;
        if (q.if_valid && !q.if_ready && (full_cycles_q != '1)) full_cycles_d = full_cycles_q + 32'd1;
        if (q.flush && (cnt_q != '0) && (flush_cnt_q != '1))    flush_cnt_d   = flush_cnt_q + 32'd1;
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_cycles_q <= '0;
            flush_cnt_q   <= '0;
        end else begin
            full_cycles_q <= full_cycles_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign stat_full_cycles = full_cycles_q;
    assign stat_flush_cnt   = flush_cnt_q;
`endif
endmodule
